wallace_mult_arbiter: RTL and testbench
=======================================

# wallace_mult_arbiter

Sequencer and round-robin arbiter that shares one combinational Wallace-tree multiplier between two requesters. It accepts one operand pair at a time over a valid/ready handshake and drives the tree's operand inputs from registers. It waits a fixed settle time, captures the product and returns it tagged with the requester id. It sits between the two client datapaths and the Wallace-tree multiplier instance built from the gate-level primitives.

## Interface
- WIDTH, 8, operand width in bits; product width is 2*WIDTH
- SETTLE, 2, whole clock cycles the tree needs after operands change; legal range 1..15
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous, active-low reset
- req0_valid  input  1  requester 0 has an operand pair
- req0_ready  output  1  requester 0 pair accepted this cycle when high with req0_valid
- req0_a, req0_b  input  WIDTH  requester 0 operands (unsigned)
- req1_valid, req1_ready, req1_a, req1_b  same as requester 0, for requester 1
- mul_a, mul_b  output  WIDTH  registered operands to the Wallace tree
- mul_p  input  2*WIDTH  product from the Wallace tree (combinational)
- resp_valid  output  1  one-cycle pulse: resp_p/resp_id valid
- resp_id  output  1  requester that owns resp_p
- resp_p  output  2*WIDTH  registered product
- busy  output  1  high while an operation is in flight (WAIT or DONE)

## Operation
- FSM states: IDLE, WAIT, DONE.
- Reset values:
  - state=IDLE
  - mul_a=mul_b=0
  - resp_valid=0, resp_id=0, resp_p=0
  - busy=0
  - settle counter=0
  - last_grant=1, so requester 0 wins the first contention.
- Arbitration in IDLE:
  - grant0 = req0_valid & (!req1_valid | last_grant==1).
  - grant1 = req1_valid & (!req0_valid | last_grant==0).
  - reqN_ready = (state==IDLE) & grantN, so at most one ready is high. Both are low outside IDLE or when no request is pending.
  - ready depends combinationally on both valids. Requesters must not derive valid from ready.
- Accept (IDLE, valid&ready at the clock edge):
  - mul_a/mul_b load the granted operands.
  - owner id and last_grant are set to the granted requester.
  - counter is loaded with SETTLE-1; state goes to WAIT.
- WAIT:
  - mul_a/mul_b are held stable.
  - the counter decrements each cycle.
  - on the edge where the counter is 0: resp_p captures mul_p, resp_id is set to owner, state goes to DONE.
- DONE: resp_valid=1 for exactly this cycle; next edge goes to IDLE. There is no response backpressure; clients must sink the pulse.
- mul_a/mul_b keep their last values in IDLE. resp_p/resp_id hold their values until the next capture.
- Arithmetic: unsigned; full 2*WIDTH product, no truncation. The block does not compute the product; it registers mul_p.
- Requester operands are sampled only at the accept edge; later changes are ignored.
- Reset mid-operation (rst_n low in WAIT or DONE):
  - all registers return to their reset values immediately.
  - the in-flight op is dropped; no resp_valid is issued.
  - last_grant returns to 1.

## Timing
- Cycle 0: handshake sampled at the end of cycle 0.
- Cycles 1..SETTLE: WAIT, with mul_a/mul_b stable.
- Cycle SETTLE+1: DONE, resp_valid high.
- Cycle SETTLE+2: IDLE; a new handshake is possible in this cycle.
- Latency from accept edge to resp_valid: SETTLE+1 cycles. Throughput: one op per SETTLE+2 cycles.
- busy is high in cycles 1..SETTLE+1.
- A request that is valid during WAIT/DONE is not accepted. It must remain valid and is arbitrated in the next IDLE cycle.
- With both requesters continuously valid, grants strictly alternate 0,1,0,1…

## Test plan
- Single op, WIDTH=8, SETTLE=2: req0 sends a=12, b=13 → req0_ready high in cycle 0. mul_a=12/mul_b=13 from cycle 1. resp_valid in cycle 3 with resp_id=0, resp_p=156. busy high in cycles 1–3. req0_ready high again in cycle 4.
- Boundary values: a=255, b=255 → resp_p=65025. a=0, b=200 → resp_p=0.
- Contention: both valid from reset with req0 (3,4) and req1 (5,6) held → responses in order id0=12, id1=30, id0=12, id1=30. Never two readys high in the same cycle.
- Stall: req1 raises valid during req0's WAIT → req1_ready stays low until the next IDLE. It is then accepted and its response is id1 with the correct product.
- Reset mid-op: assert rst_n low in cycle 2 of an op → all outputs 0 immediately and no resp_valid afterwards. After release, the first contention is granted to req0.
- SETTLE=4 build: accept at cycle 0 → resp_valid exactly in cycle 5. mul_a/mul_b are unchanged in cycles 1–4 even when req operands toggle.

Source files
------------

// File: rtl/wallace_mult_arbiter.sv
// Round-robin sequencer sharing one combinational Wallace-tree multiplier
// between two requesters; settles SETTLE cycles, then returns a tagged product.
module wallace_mult_arbiter #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic [2*WIDTH-1:0] mul_p,
    output logic               resp_valid,
    output logic               resp_id,
    output logic [2*WIDTH-1:0] resp_p,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic       owner;
    logic       last_grant;
    logic       grant0;
    logic       grant1;
    logic       accept;

    // last_grant==1 means requester 1 went last, so requester 0 wins a tie
    always_comb begin
        grant0     = req0_valid & (~req1_valid | last_grant);
        grant1     = req1_valid & (~req0_valid | ~last_grant);
        req0_ready = (state == IDLE) & grant0;
        req1_ready = (state == IDLE) & grant1;
        accept     = req0_ready | req1_ready;
        resp_valid = (state == DONE);
        busy       = (state != IDLE);
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = WAIT;
            WAIT: if (cnt == 4'd0) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a      <= '0;
            mul_b      <= '0;
            resp_p     <= '0;
            resp_id    <= 1'b0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= 4'd0;
        end else if (accept) begin
            mul_a      <= grant0 ? req0_a : req1_a;
            mul_b      <= grant0 ? req0_b : req1_b;
            owner      <= grant1;
            last_grant <= grant1;
            cnt        <= CNT_INIT;
        end else if (state == WAIT) begin
            if (cnt == 4'd0) begin
                resp_p  <= mul_p;
                resp_id <= owner;
            end else begin
                cnt <= cnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_wallace_mult_arbiter.sv
// Directed bench for wallace_mult_arbiter: SETTLE=2 and SETTLE=4 instances,
// each fed by a tree model whose product is garbage until it has settled.
module tb_wallace_mult_arbiter;

    logic        clk;
    logic        rst_n;
    int          total;
    int          bad;

    logic        r0v, r0r, r1v, r1r;
    logic [7:0]  r0a, r0b, r1a, r1b;
    logic [7:0]  ma, mb;
    logic [15:0] mp;
    logic        rv, rid, bsy;
    logic [15:0] rp;

    logic        s0v, s0r, s1v, s1r;
    logic [7:0]  s0a, s0b, s1a, s1b;
    logic [7:0]  ma4, mb4;
    logic [15:0] mp4;
    logic        rv4, rid4, bsy4;
    logic [15:0] rp4;

    wallace_mult_arbiter #(.WIDTH(8), .SETTLE(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0v), .req0_ready(r0r), .req0_a(r0a), .req0_b(r0b),
        .req1_valid(r1v), .req1_ready(r1r), .req1_a(r1a), .req1_b(r1b),
        .mul_a(ma), .mul_b(mb), .mul_p(mp),
        .resp_valid(rv), .resp_id(rid), .resp_p(rp), .busy(bsy)
    );

    wallace_mult_arbiter #(.WIDTH(8), .SETTLE(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(s0v), .req0_ready(s0r), .req0_a(s0a), .req0_b(s0b),
        .req1_valid(s1v), .req1_ready(s1r), .req1_a(s1a), .req1_b(s1b),
        .mul_a(ma4), .mul_b(mb4), .mul_p(mp4),
        .resp_valid(rv4), .resp_id(rid4), .resp_p(rp4), .busy(bsy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tree model: output is only trustworthy after operands held N cycles
    int         age2 = 15;
    int         age4 = 15;
    logic [7:0] pa2 = '0, pb2 = '0, pa4 = '0, pb4 = '0;

    always @(negedge clk) begin
        if (ma !== pa2 || mb !== pb2) age2 = 1;
        else if (age2 < 15) age2++;
        pa2 = ma;
        pb2 = mb;
        if (ma4 !== pa4 || mb4 !== pb4) age4 = 1;
        else if (age4 < 15) age4++;
        pa4 = ma4;
        pb4 = mb4;
    end

    assign mp  = (age2 >= 2) ? 16'(ma) * 16'(mb) : 16'hdead;
    assign mp4 = (age4 >= 4) ? 16'(ma4) * 16'(mb4) : 16'hbeef;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        {r0v, r1v, s0v, s1v} = '0;
        {r0a, r0b, r1a, r1b} = '0;
        {s0a, s0b, s1a, s1b} = '0;
        #2;
        total++;
        if ({rv, rid, rp, bsy, ma, mb} !== 35'd0) begin
            bad++;
            $display("FAIL reset_outputs got rv=%0b id=%0b p=%0d busy=%0b a=%0d b=%0d want all 0",
                     rv, rid, rp, bsy, ma, mb);
        end
        total++;
        if ({r0r, r1r} !== 2'b00) begin
            bad++;
            $display("FAIL reset_ready got %b want 00", {r0r, r1r});
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        r0v = 1'b1; r0a = 8'd12; r0b = 8'd13;
        #1;
        total++;
        if (r0r !== 1'b1 || r1r !== 1'b0) begin
            bad++;
            $display("FAIL single_ready0 got r0=%b r1=%b want 1 0", r0r, r1r);
        end
        tick();
        r0v = 1'b0; r0a = 8'd99; r0b = 8'd98;
        #1;
        for (int c = 1; c <= 2; c++) begin
            total++;
            if (ma !== 8'd12 || mb !== 8'd13 || bsy !== 1'b1 || rv !== 1'b0) begin
                bad++;
                $display("FAIL single_wait c%0d got a=%0d b=%0d busy=%b rv=%b want 12 13 1 0",
                         c, ma, mb, bsy, rv);
            end
            tick();
        end
        total++;
        if (rv !== 1'b1 || rid !== 1'b0 || rp !== 16'd156 || bsy !== 1'b1) begin
            bad++;
            $display("FAIL single_resp got rv=%b id=%b p=%0d busy=%b want 1 0 156 1",
                     rv, rid, rp, bsy);
        end
        tick();
        r0v = 1'b1;
        #1;
        total++;
        if (rv !== 1'b0 || bsy !== 1'b0 || r0r !== 1'b1 || rp !== 16'd156) begin
            bad++;
            $display("FAIL single_idle got rv=%b busy=%b r0=%b p=%0d want 0 0 1 156",
                     rv, bsy, r0r, rp);
        end
        r0v = 1'b0;
        #1;
    endtask

    task automatic test_boundary();
        logic [7:0]  ta [3] = '{8'd255, 8'd0, 8'd1};
        logic [7:0]  tb [3] = '{8'd255, 8'd200, 8'd1};
        logic [15:0] tp [3] = '{16'd65025, 16'd0, 16'd1};
        for (int i = 0; i < 3; i++) begin
            r0v = 1'b1; r0a = ta[i]; r0b = tb[i];
            tick();
            r0v = 1'b0;
            for (int c = 0; c < 2; c++) tick();
            total++;
            if (rv !== 1'b1 || rp !== tp[i] || rid !== 1'b0) begin
                bad++;
                $display("FAIL boundary_%0d got rv=%b p=%0d id=%b want 1 %0d 0",
                         i, rv, rp, rid, tp[i]);
            end
            tick();
        end
    endtask

    task automatic test_contention();
        logic        eid [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [15:0] ep  [4] = '{16'd12, 16'd30, 16'd12, 16'd30};
        int n = 0;
        int cyc = 0;
        int last = 0;
        rst_n = 1'b0;
        r0v = 1'b1; r0a = 8'd3; r0b = 8'd4;
        r1v = 1'b1; r1a = 8'd5; r1b = 8'd6;
        tick();
        rst_n = 1'b1;
        #1;
        while (n < 4 && cyc < 40) begin
            total++;
            if (r0r === 1'b1 && r1r === 1'b1) begin
                bad++;
                $display("FAIL contention_two_ready cyc%0d got 11 want at most one", cyc);
            end
            if (rv === 1'b1) begin
                total++;
                if (rid !== eid[n] || rp !== ep[n]) begin
                    bad++;
                    $display("FAIL contention_resp%0d got id=%b p=%0d want id=%b p=%0d",
                             n, rid, rp, eid[n], ep[n]);
                end
                if (n > 0) begin
                    total++;
                    if (cyc - last !== 4) begin
                        bad++;
                        $display("FAIL contention_spacing%0d got %0d want 4", n, cyc - last);
                    end
                end
                last = cyc;
                n++;
            end
            tick();
            cyc++;
        end
        total++;
        if (n !== 4) begin
            bad++;
            $display("FAIL contention_timeout got %0d responses want 4", n);
        end
        r0v = 1'b0;
        r1v = 1'b0;
        #1;
    endtask

    task automatic test_stall();
        r0v = 1'b1; r0a = 8'd20; r0b = 8'd3;
        tick();
        r0v = 1'b0;
        r1v = 1'b1; r1a = 8'd7; r1b = 8'd9;
        for (int c = 1; c <= 3; c++) begin
            #1;
            total++;
            if (r1r !== 1'b0 || ma !== 8'd20 || mb !== 8'd3) begin
                bad++;
                $display("FAIL stall_c%0d got r1=%b a=%0d b=%0d want 0 20 3", c, r1r, ma, mb);
            end
            if (c == 3) begin
                total++;
                if (rv !== 1'b1 || rp !== 16'd60 || rid !== 1'b0) begin
                    bad++;
                    $display("FAIL stall_resp0 got rv=%b p=%0d id=%b want 1 60 0", rv, rp, rid);
                end
            end
            tick();
        end
        total++;
        if (r1r !== 1'b1) begin
            bad++;
            $display("FAIL stall_accept got r1=%b want 1", r1r);
        end
        tick();
        r1v = 1'b0;
        tick();
        tick();
        total++;
        if (rv !== 1'b1 || rid !== 1'b1 || rp !== 16'd63) begin
            bad++;
            $display("FAIL stall_resp1 got rv=%b id=%b p=%0d want 1 1 63", rv, rid, rp);
        end
        tick();
    endtask

    task automatic test_reset_midop();
        r1v = 1'b1; r1a = 8'd10; r1b = 8'd11;
        tick();
        r1v = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        total++;
        if ({rv, rid, rp, bsy, ma, mb} !== 35'd0) begin
            bad++;
            $display("FAIL midop_reset got rv=%b id=%b p=%0d busy=%b a=%0d b=%0d want all 0",
                     rv, rid, rp, bsy, ma, mb);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            total++;
            if (rv !== 1'b0 || bsy !== 1'b0) begin
                bad++;
                $display("FAIL midop_noresp c%0d got rv=%b busy=%b want 0 0", c, rv, bsy);
            end
        end
        r0v = 1'b1; r0a = 8'd2; r0b = 8'd2;
        r1v = 1'b1; r1a = 8'd4; r1b = 8'd4;
        #1;
        total++;
        if (r0r !== 1'b1 || r1r !== 1'b0) begin
            bad++;
            $display("FAIL midop_first_grant got r0=%b r1=%b want 1 0", r0r, r1r);
        end
        tick();
        r0v = 1'b0;
        r1v = 1'b0;
        for (int c = 0; c < 4; c++) tick();
    endtask

    task automatic test_settle4();
        s0v = 1'b1; s0a = 8'd9; s0b = 8'd10;
        #1;
        total++;
        if (s0r !== 1'b1) begin
            bad++;
            $display("FAIL s4_ready got %b want 1", s0r);
        end
        tick();
        s0v = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            s0a = 8'($urandom);
            s0b = 8'($urandom);
            s1a = 8'($urandom);
            #1;
            total++;
            if (ma4 !== 8'd9 || mb4 !== 8'd10 || rv4 !== 1'b0 || bsy4 !== 1'b1) begin
                bad++;
                $display("FAIL s4_wait_c%0d got a=%0d b=%0d rv=%b busy=%b want 9 10 0 1",
                         c, ma4, mb4, rv4, bsy4);
            end
            tick();
        end
        total++;
        if (rv4 !== 1'b1 || rp4 !== 16'd90 || rid4 !== 1'b0) begin
            bad++;
            $display("FAIL s4_resp got rv=%b p=%0d id=%b want 1 90 0", rv4, rp4, rid4);
        end
        tick();
        total++;
        if (rv4 !== 1'b0 || bsy4 !== 1'b0) begin
            bad++;
            $display("FAIL s4_idle got rv=%b busy=%b want 0 0", rv4, bsy4);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_single();
        test_boundary();
        test_contention();
        test_stall();
        test_reset_midop();
        test_settle4();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
